// File: rtl/ucode_sequencer_if.sv
// Fetch-side and ROM-side signals of the multiply microcode sequencer.
// master drives requests and ROM data; slave is the sequencer.
interface ucode_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic [6:0]        mul_opcode;
  logic [3:0]        mul_rd;
  logic [3:0]        mul_rs;
  logic [15:0]       mul_imm;
  logic              stall;
  logic              abort;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic [31:0]       ucode_instruction;
  logic              ucode_valid;
  logic              ucode_flag;
  logic              ucode_done;
  logic              illegal_op;
  logic [15:0]       ucode_count;

  modport master (
    output start, mul_opcode, mul_rd, mul_rs, mul_imm, stall, abort, rom_data,
    input  rom_addr, ucode_instruction, ucode_valid, ucode_flag, ucode_done,
           illegal_op, ucode_count
  );

  modport slave (
    input  start, mul_opcode, mul_rd, mul_rs, mul_imm, stall, abort, rom_data,
    output rom_addr, ucode_instruction, ucode_valid, ucode_flag, ucode_done,
           illegal_op, ucode_count
  );
endinterface

// File: rtl/ucode_sequencer.sv
// Multiply microcode sequencer: first word 1 cycle after start, done pulse after LEN words; stall freezes RUN, abort cancels.
// Defining UCODE_PERF_EN builds the saturating issued-word counter driven on ucode_count.
module ucode_sequencer #(
  parameter int          ADDR_W  = 5,
  parameter int          ENTRY0  = 0,
  parameter int          LEN0    = 6,
  parameter int          ENTRY1  = 6,
  parameter int          LEN1    = 6,
  parameter int          ENTRY2  = 12,
  parameter int          LEN2    = 8,
  parameter int          ENTRY3  = 20,
  parameter int          LEN3    = 8,
  parameter logic [3:0]  RD_TAG  = 4'hE,
  parameter logic [3:0]  RS_TAG  = 4'hD,
  parameter logic [15:0] IMM_TAG = 16'hFFFF
) (
  input logic              clk,
  input logic              rst,
  ucode_sequencer_if.slave bus
);
  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] sel_entry;
  logic [LEN_W-1:0]  sel_len;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  step_q;
  logic [3:0]        rd_q;
  logic [3:0]        rs_q;
  logic [15:0]       imm_q;
  logic              legal;
  logic              last_step;
  logic              illegal_q;
  logic              accept;

  always_comb begin
    legal     = 1'b1;
    sel_entry = '0;
    sel_len   = '0;
    case (bus.mul_opcode)
      7'b0010000: begin sel_entry = ADDR_W'(ENTRY0); sel_len = LEN_W'(LEN0); end
      7'b0011000: begin sel_entry = ADDR_W'(ENTRY1); sel_len = LEN_W'(LEN1); end
      7'b0110000: begin sel_entry = ADDR_W'(ENTRY2); sel_len = LEN_W'(LEN2); end
      7'b0111000: begin sel_entry = ADDR_W'(ENTRY3); sel_len = LEN_W'(LEN3); end
      default:    legal = 1'b0;
    endcase
  end

  assign accept    = (state == IDLE) && bus.start && legal;
  assign last_step = (step_q == (len_q - LEN_W'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN: begin
        if (bus.abort)                       state_nxt = IDLE;
        else if (!bus.stall && last_step)    state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tagged operand fields are replaced independently; opcode bits and bit 16 always pass through.
  always_comb begin
    bus.ucode_valid       = 1'b0;
    bus.ucode_flag        = 1'b0;
    bus.ucode_done        = 1'b0;
    bus.ucode_instruction = '0;
    case (state)
      RUN: begin
        bus.ucode_valid       = 1'b1;
        bus.ucode_flag        = 1'b1;
        bus.ucode_instruction = bus.rom_data;
        if (bus.rom_data[24:21] == RD_TAG)  bus.ucode_instruction[24:21] = rd_q;
        if (bus.rom_data[20:17] == RS_TAG)  bus.ucode_instruction[20:17] = rs_q;
        if (bus.rom_data[15:0]  == IMM_TAG) bus.ucode_instruction[15:0]  = imm_q;
      end
      DONE: begin
        bus.ucode_flag = 1'b1;
        bus.ucode_done = !bus.abort;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      len_q     <= '0;
      step_q    <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= (state == IDLE) && bus.start && !legal;
      if (accept) begin
        addr_q <= sel_entry;
        len_q  <= sel_len;
        step_q <= '0;
        rd_q   <= bus.mul_rd;
        rs_q   <= bus.mul_rs;
        imm_q  <= bus.mul_imm;
      end else if ((state == RUN) && !bus.abort && !bus.stall && !last_step) begin
        addr_q <= addr_q + ADDR_W'(1);
        step_q <= step_q + LEN_W'(1);
      end
    end
  end

  assign bus.rom_addr   = addr_q;
  assign bus.illegal_op = illegal_q;

`ifdef UCODE_PERF_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count_q <= '0;
    else if ((state == RUN) && !bus.stall && !bus.abort && (count_q != 16'hFFFF))
      count_q <= count_q + 16'd1;
  end

  assign bus.ucode_count = count_q;
`else
  assign bus.ucode_count = 16'h0000;
`endif
endmodule

// File: tb/tb_ucode_sequencer.sv
// Scoreboard bench for ucode_sequencer: expected words queued at start, compared as they issue.
module tb_ucode_sequencer;
  logic clk;
  logic rst;

  ucode_sequencer_if #(.ADDR_W(5)) bus();

  ucode_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rom[32];
  int          n_chk;
  int          n_err;

  int         entry_t[4] = '{0, 6, 12, 20};
  int         len_t[4]   = '{6, 6, 8, 8};
  logic [6:0] opc_t[4]   = '{7'b0010000, 7'b0011000, 7'b0110000, 7'b0111000};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.rom_data = rom[bus.rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] subst(input logic [31:0] w, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [15:0] imm);
    logic [31:0] r;
    r = w;
    if (w[24:21] == 4'hE)     r[24:21] = rd;
    if (w[20:17] == 4'hD)     r[20:17] = rs;
    if (w[15:0]  == 16'hFFFF) r[15:0]  = imm;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst && bus.ucode_valid) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        chk("rom_addr", bus.rom_addr, sb[0].addr);
        chk("instr", bus.ucode_instruction, sb[0].instr);
        if (!bus.stall && !bus.abort) void'(sb.pop_front());
      end
    end
  end

  // Called at posedge+2; start is sampled at the next posedge (cycle N), returns in cycle N+1.
  task automatic issue(input int idx, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [15:0] imm, input string tag);
    logic [4:0] a;
    bus.start      = 1'b1;
    bus.mul_opcode = opc_t[idx];
    bus.mul_rd     = rd;
    bus.mul_rs     = rs;
    bus.mul_imm    = imm;
    for (int i = 0; i < len_t[idx]; i++) begin
      a = 5'(entry_t[idx] + i);
      sb.push_back('{a, subst(rom[a], rd, rs, imm)});
    end
    @(negedge clk);
    chk({tag, "_pre_flag"}, bus.ucode_flag, 0);
    chk({tag, "_pre_valid"}, bus.ucode_valid, 0);
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  task automatic run(input int idx, input logic [3:0] rd, input logic [3:0] rs,
                     input logic [15:0] imm, input int stall_k, input int stall_n,
                     input int abort_k, input string tag);
    int done_k;
    int done_cnt;
    int n;
    done_k   = 0;
    done_cnt = 0;
    issue(idx, rd, rs, imm, tag);
    n = (abort_k != 0) ? abort_k : len_t[idx] + stall_n + 3;
    for (int k = 1; k <= n; k++) begin
      bus.stall = (k >= stall_k) && (k < stall_k + stall_n);
      bus.abort = (k == abort_k);
      @(negedge clk);
      if (bus.ucode_done) begin
        done_cnt++;
        if (done_k == 0) done_k = k;
      end
      if (k == 1) chk({tag, "_flag_run"}, bus.ucode_flag, 1);
      if (k == 1 && tag == "t1")
        chk("t1_word0", bus.ucode_instruction, {7'h10, 4'd3, 4'd5, 1'b0, 16'h0042});
      if (bus.stall) chk({tag, "_hold"}, bus.rom_addr, 32'(5'(entry_t[idx] + stall_k - 1)));
      if (abort_k == 0 && k == len_t[idx] + stall_n + 2) chk({tag, "_flag_end"}, bus.ucode_flag, 0);
      @(posedge clk); #2;
      if (k == abort_k) sb.delete();
    end
    bus.stall = 1'b0;
    bus.abort = 1'b0;
    chk({tag, "_done_at"}, done_k, (abort_k != 0) ? 0 : 1 + len_t[idx] + stall_n);
    chk({tag, "_done_cnt"}, done_cnt, (abort_k != 0) ? 0 : 1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 32; i++)
      rom[i] = {7'(i + 1), (i % 2 == 0) ? 4'hE : 4'(i), (i % 3 == 0) ? 4'hD : 4'(i + 3),
                1'(i), (i % 2 == 1) ? 16'hFFFF : 16'(i * 273)};
    rom[0] = {7'h10, 4'hE, 4'hD, 1'b0, 16'hFFFF};

    rst = 1'b0;
    bus.start = 1'b0; bus.mul_opcode = '0; bus.mul_rd = '0; bus.mul_rs = '0;
    bus.mul_imm = '0; bus.stall = 1'b0; bus.abort = 1'b0;
    #3;
    chk("rst_addr", bus.rom_addr, 0);
    chk("rst_instr", bus.ucode_instruction, 0);
    chk("rst_valid", bus.ucode_valid, 0);
    chk("rst_flag", bus.ucode_flag, 0);
    chk("rst_done", bus.ucode_done, 0);
    chk("rst_illegal", bus.illegal_op, 0);
    chk("rst_count", bus.ucode_count, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    run(0, 4'd3, 4'd5, 16'h0042, 0, 0, 0, "t1");
    run(2, 4'd1, 4'd2, 16'h1234, 3, 3, 0, "t3");

    bus.start = 1'b1;
    bus.mul_opcode = 7'b0000001;
    @(negedge clk);
    chk("ill_cycN", bus.illegal_op, 0);
    @(posedge clk); #2;
    bus.start = 1'b0;
    @(negedge clk);
    chk("ill_pulse", bus.illegal_op, 1);
    chk("ill_valid", bus.ucode_valid, 0);
    chk("ill_flag", bus.ucode_flag, 0);
    @(posedge clk); #2;
    @(negedge clk);
    chk("ill_clear", bus.illegal_op, 0);
    @(posedge clk); #2;

    run(3, 4'd7, 4'd8, 16'hBEEF, 0, 0, 5, "t5");
    run(1, 4'd9, 4'd10, 16'h5555, 0, 0, 0, "t5b");

    issue(0, 4'd2, 4'd6, 16'h00AA, "t6");
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_addr", bus.rom_addr, 0);
    chk("arst_instr", bus.ucode_instruction, 0);
    chk("arst_valid", bus.ucode_valid, 0);
    chk("arst_flag", bus.ucode_flag, 0);
    chk("arst_done", bus.ucode_done, 0);
    chk("arst_count", bus.ucode_count, 0);
    sb.delete();
    @(posedge clk); #2;
    rst = 1'b1;

    run(0, 4'd11, 4'd12, 16'h0F0F, 0, 0, 0, "p1");
    run(1, 4'd13, 4'd14, 16'hF0F0, 0, 0, 0, "p2");
    @(negedge clk);
`ifdef UCODE_PERF_EN
    chk("perf_count", bus.ucode_count, 12);
`else
    chk("perf_count", bus.ucode_count, 0);
`endif
    chk("sb_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
